axi_stream_input: RTL and testbench

AXI4-Stream slave that receives result/operand words from the host DMA and writes them into the NPU input SRAM, one SRAM word per accepted beat. It is the receive-side counterpart of the NPU's stream output path. Each beat carries `groups` packed elements, and a frame ends after `in_size` elements. A 2-entry buffer absorbs SRAM write stalls without dropping beats.

---
 rtl/axi_stream_input.sv | 147 ++++++++++++++
 tb/tb_axi_stream_input.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axi_stream_input.sv
// axi_stream_input: AXI4-Stream slave writing one NPU input SRAM word per beat through a 2-entry buffer; tlast checking enabled by AXIS_IN_TLAST_CHECK_EN
module axi_stream_input #(
  parameter int ADDR_WIDTH = 13,
  parameter int SRAM_WIDTH = 64,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [SRAM_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  start_input,
  input  logic [SIZE_WIDTH-1:0] in_size,
  input  logic [3:0]            groups,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  sram_in_stall,
  output logic                  sram_in_en,
  output logic [ADDR_WIDTH-1:0] sram_in_addr,
  output logic [SRAM_WIDTH-1:0] sram_in_data,
  output logic                  busy,
  output logic                  input_done,
  output logic [ADDR_WIDTH-1:0] beat_count,
  output logic                  err_early_tlast,
  output logic                  err_missing_tlast
);
  localparam int EW = SIZE_WIDTH + 4;
  localparam int BW = SRAM_WIDTH + ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [3:0] groups_q, groups_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, beat_q, beat_d, addr_q, addr_d;
  logic [EW-1:0] elem_q, elem_d, elem_sum;
  logic [BW-1:0] mem_q [2];
  logic [BW-1:0] mem_d [2];
  logic [BW-1:0] head;
  logic wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic tready_q, tready_d, en_q, en_d;
  logic [SRAM_WIDTH-1:0] data_q, data_d;
  logic start, accept, last, tlast_end, pop;
  assign start    = start_input && state_q == IDLE;
  assign accept   = s_axis_tvalid && tready_q;
  assign elem_sum = elem_q + EW'(groups_q);
  assign last     = elem_sum >= EW'(size_q);
  assign pop      = cnt_q != 2'd0 && !sram_in_stall;
  assign head     = mem_q[rptr_q];
  assign s_axis_tready = tready_q;
  assign sram_in_en    = en_q;
  assign sram_in_addr  = addr_q;
  assign sram_in_data  = data_q;
  assign beat_count    = beat_q;
`ifdef AXIS_IN_TLAST_CHECK_EN
  logic err_early_q, err_early_d, err_missing_q, err_missing_d;
  assign tlast_end = s_axis_tlast;
  assign err_early_tlast   = err_early_q;
  assign err_missing_tlast = err_missing_q;
  // sticky tlast mismatch flags, cleared by an accepted start
  always_comb begin
    err_early_d   = start ? 1'b0 : err_early_q | (accept && s_axis_tlast && !last);
    err_missing_d = start ? 1'b0 : err_missing_q | (accept && last && !s_axis_tlast);
  end
  // error flag registers
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign tlast_end = 1'b0;
  assign err_early_tlast   = 1'b0;
  assign err_missing_tlast = 1'b0;
`endif
  // frame sequencing: receive until the element count is covered, then drain the buffer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (in_size == '0 ? DONE : RECV) : IDLE;
      RECV:    state_d = accept && (last || tlast_end) ? DRAIN : RECV;
      DRAIN:   state_d = cnt_q == 2'd0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // status outputs decoded from the frame state
  always_comb begin
    busy       = state_q == RECV || state_q == DRAIN;
    input_done = state_q == DONE;
  end
  // frame parameters, counters, buffer and SRAM write port
  always_comb begin
    size_d   = start ? in_size : size_q;
    groups_d = start ? (groups == 4'd0 ? 4'd1 : groups) : groups_q;
    base_d   = start ? base_addr : base_q;
    elem_d   = start ? '0 : accept ? elem_sum : elem_q;
    beat_d   = start ? '0 : accept ? beat_q + 1'b1 : beat_q;
    mem_d    = mem_q;
    if (accept) mem_d[wptr_q] = {s_axis_tdata, base_q + beat_q};
    wptr_d   = wptr_q ^ accept;
    rptr_d   = rptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, accept} - {1'b0, pop};
    en_d     = pop;
    addr_d   = pop ? head[ADDR_WIDTH-1:0] : addr_q;
    data_d   = pop ? head[BW-1 -: SRAM_WIDTH] : data_q;
    tready_d = state_d == RECV && cnt_d != 2'd2;
  end
  // state and datapath registers; reset drops any buffered beats
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q  <= IDLE;
      size_q   <= '0;
      groups_q <= '0;
      base_q   <= '0;
      elem_q   <= '0;
      beat_q   <= '0;
      mem_q    <= '{default: '0};
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      groups_q <= groups_d;
      base_q   <= base_d;
      elem_q   <= elem_d;
      beat_q   <= beat_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tready_q <= tready_d;
    end
  end
endmodule

// File: tb/tb_axi_stream_input.sv
// tb_axi_stream_input: randomized scoreboard bench for axi_stream_input
module tb_axi_stream_input;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int SW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast, start_input, sram_in_stall;
  logic [SW-1:0] in_size;
  logic [3:0] groups;
  logic [AW-1:0] base_addr, sram_in_addr, beat_count;
  logic sram_in_en, busy, input_done, err_early_tlast, err_missing_tlast;
  logic [DW-1:0] sram_in_data;
  always #5 clk = ~clk;
  axi_stream_input #(.ADDR_WIDTH(AW), .SRAM_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .start_input(start_input), .in_size(in_size), .groups(groups),
    .base_addr(base_addr), .sram_in_stall(sram_in_stall), .sram_in_en(sram_in_en),
    .sram_in_addr(sram_in_addr), .sram_in_data(sram_in_data), .busy(busy), .input_done(input_done),
    .beat_count(beat_count), .err_early_tlast(err_early_tlast), .err_missing_tlast(err_missing_tlast)
  );
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard monitor: every SRAM write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (!rst && sram_in_en) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: got addr %0h data %0h expected no write", sram_in_addr, sram_in_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(sram_in_addr), 64'(e.addr));
        chk("wr_data", sram_in_data, e.data);
      end
    end
  end
  // mode 0: tlast on the expected last beat; mode 1: tlast on beat k only; mode 2: no tlast
  task automatic run_frame(input int size, input int g, input int base, input int vpct, input int spct,
                           input int sf, input int sl, input int mode, input int k, input bit tchk, input bit dchk);
    int geff, nbe, nb, i, t, start_cyc;
    bit ee, em, dropped, tr_after, early, tl_last;
    logic [DW-1:0] data[$];
    geff = (g % 16 == 0) ? 1 : g % 16;
    nbe = (size + geff - 1) / geff;
    nb = nbe;
    ee = 0;
    em = 0;
    dropped = 0;
    tr_after = 0;
    early = mode == 1 && k < nbe - 1;
    tl_last = mode == 0 || (mode == 1 && k == nbe - 1);
`ifdef AXIS_IN_TLAST_CHECK_EN
    if (early) begin
      nb = k + 1;
      ee = 1;
    end else if (nbe > 0 && !tl_last) em = 1;
`endif
    for (int j = 0; j < nbe; j++) data.push_back({$urandom, $urandom});
    for (int j = 0; j < nb; j++) exp_q.push_back('{addr: AW'(base + j), data: data[j]});
    @(negedge clk);
    start_input = 1;
    in_size = SW'(size);
    groups = 4'(g);
    base_addr = AW'(base);
    @(negedge clk);
    start_input = 0;
    in_size = SW'($urandom);
    groups = 4'($urandom);
    base_addr = AW'($urandom);
    start_cyc = cyc;
    i = 0;
    t = 0;
    while (i < nb && t < 3000) begin
      sram_in_stall = (t >= sf && t < sf + sl) || ($urandom_range(99) < spct);
      s_axis_tvalid = $urandom_range(99) < vpct;
      s_axis_tdata = data[i];
      s_axis_tlast = (mode == 0 && i == nbe - 1) || (mode == 1 && i == k);
      if (sram_in_stall && s_axis_tvalid && !s_axis_tready) dropped = 1;
      if (s_axis_tvalid && s_axis_tready) i++;
      t++;
      @(negedge clk);
    end
    chk("beats_sent", 64'(i), 64'(nb));
    s_axis_tvalid = 1;
    s_axis_tdata = {$urandom, $urandom};
    s_axis_tlast = 0;
    while (!input_done && t < 3300) begin
      if (s_axis_tready) tr_after = 1;
      sram_in_stall = (t >= sf && t < sf + sl) || ($urandom_range(99) < spct);
      t++;
      @(negedge clk);
    end
    chk("done_seen", 64'(input_done), 64'(1));
    chk("ready_after_last", 64'(tr_after), 64'(0));
    chk("beat_count", 64'(beat_count), 64'(nb));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("writes_left", 64'(exp_q.size()), 64'(0));
    chk("err_early", 64'(err_early_tlast), 64'(ee));
    chk("err_missing", 64'(err_missing_tlast), 64'(em));
    if (nb > 0) chk("done_after_last_write", 64'(cyc - last_wr_cyc), 64'(1));
    if (tchk) chk("done_latency", 64'(cyc - start_cyc), 64'(nb == 0 ? 0 : nb + 2));
    if (dchk) chk("ready_drop_in_stall", 64'(dropped), 64'(1));
    s_axis_tvalid = 0;
    sram_in_stall = 0;
    @(negedge clk);
    chk("done_pulse_len", 64'(input_done), 64'(0));
    chk("beat_count_hold", 64'(beat_count), 64'(nb));
  endtask
  initial begin
    s_axis_tdata = '0;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    start_input = 0;
    sram_in_stall = 0;
    in_size = '0;
    groups = '0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({s_axis_tready, sram_in_en, sram_in_addr, busy, input_done, beat_count,
        err_early_tlast, err_missing_tlast}), 64'(0));
    chk("reset_data", sram_in_data, 64'(0));
    rst = 0;
    run_frame(8, 2, 'h10, 100, 0, 0, 0, 0, 0, 1, 0);
    run_frame(7, 2, 'h20, 100, 0, 0, 0, 0, 0, 1, 0);
    run_frame(16, 2, 'h30, 100, 0, 3, 5, 0, 0, 0, 1);
    run_frame(0, 3, 'h50, 100, 0, 0, 0, 0, 0, 1, 0);
    run_frame(3, 1, 'h1FFF, 100, 0, 0, 0, 0, 0, 1, 0);
    run_frame(8, 1, 'h60, 100, 0, 0, 0, 1, 2, 0, 0);
    run_frame(8, 1, 'h70, 100, 0, 0, 0, 2, 0, 0, 0);
    run_frame(5, 0, 'h80, 100, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    start_input = 1;
    in_size = 6;
    groups = 1;
    base_addr = 'h40;
    @(negedge clk);
    start_input = 0;
    s_axis_tvalid = 1;
    s_axis_tdata = 64'h1111;
    @(negedge clk);
    chk("pre_reset_beats", 64'(beat_count), 64'(1));
    s_axis_tdata = 64'h2222;
    rst = 1;
    #1;
    chk("midframe_reset_outputs", 64'({s_axis_tready, sram_in_en, sram_in_addr, busy, input_done, beat_count,
        err_early_tlast, err_missing_tlast}), 64'(0));
    chk("midframe_reset_data", sram_in_data, 64'(0));
    s_axis_tvalid = 0;
    @(negedge clk);
    rst = 0;
    run_frame(6, 1, 'h123, 100, 0, 0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 20; n++)
      run_frame($urandom_range(0, 40), $urandom_range(0, 15), $urandom_range(0, 8191), $urandom_range(50, 100),
                $urandom_range(0, 40), 0, 0, $urandom_range(0, 2), $urandom_range(0, 10), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
